gpio_mux_ctrl: RTL and testbench
================================

# gpio_mux_ctrl

Sequencer that drives the packed 3-bit-plus GPIO control word (enable, drop, select) for the stream mux. It sits on the fabric side, between a software-facing request handshake and the mux's GPIO control input. It switches paths safely: it stops new packets, waits for the stream to reach a packet boundary, optionally flushes a stuck packet, changes the select, lets it settle, and then re-enables the mux.

## Interface
- SEL_WIDTH, 1: width of the select field; must be ≥1.
- SETTLE_CYCLES, 4: cycles held in SWITCH and FLUSH; must be ≥1.
- DRAIN_TIMEOUT, 256: maximum number of DRAIN cycles before a forced flush; must be ≥1.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request ready; high only in IDLE or ACTIVE.
- req_sel  in  SEL_WIDTH  requested mux select.
- req_enable  in  1  1 = run the mux on req_sel; 0 = park it disabled.
- mon_tvalid, mon_tready, mon_tlast  in  1 each  passive monitor of the mux output stream.
- gpio  out  SEL_WIDTH+2  registered control word:
  - [0] = enable
  - [1] = drop
  - [2 +: SEL_WIDTH] = sel
- busy  out  1  high in DRAIN, FLUSH and SWITCH.
- done  out  1  one-cycle pulse when a request completes.
- done_timeout  out  1  valid with done; 1 if that request needed a forced flush.

## Operation
- **States:** IDLE, ACTIVE, DRAIN, FLUSH, SWITCH. Reset enters IDLE.
- **Reset values:** gpio=0, req_ready=0 during reset, busy=0, done=0, done_timeout=0, in_packet=0, counters=0.
- **Packet tracking:** a beat is mon_tvalid&&mon_tready.
  - in_packet is set by a beat with mon_tlast=0.
  - in_packet is cleared by a beat with mon_tlast=1.
  - in_packet is forced to 0 on leaving FLUSH.
- **IDLE (enable=0, drop=0):**
  - Accepted request with req_enable=1: go to SWITCH and load sel=req_sel.
  - Accepted request with req_enable=0: done pulses the next cycle; stay in IDLE.
- **ACTIVE (enable=1):**
  - Accepted request with req_enable=1 and req_sel equal to the current sel: no change; done pulses the next cycle.
  - Any other accepted request: go to DRAIN with enable=0, and latch the request.
- **DRAIN (enable=0):**
  - If in_packet==0: go to SWITCH when the latched req_enable=1, otherwise go to IDLE with done pulsed.
  - If the timeout counter reaches DRAIN_TIMEOUT-1 while in_packet==1: go to FLUSH (only with the macro).
- **FLUSH (drop=1, enable=0):** lasts SETTLE_CYCLES. Then go to SWITCH, or to IDLE if req_enable=0. Sets done_timeout for this request.
- **SWITCH (enable=0, drop=0):** sel is loaded on entry. Lasts SETTLE_CYCLES, then go to ACTIVE with enable=1 and done pulsed in that same cycle.
- **Reset mid-operation:** asynchronously returns to IDLE with all outputs zero; a pending request is discarded.
- **Counter width:** counters are $clog2(max(SETTLE_CYCLES,DRAIN_TIMEOUT))+1 bits wide and reset on every state entry.

## Timing
- **Cycle N** is the accept cycle (req_valid&&req_ready).
- **IDLE→run:** sel updates at N+1; enable=1 and done at N+1+SETTLE_CYCLES.
- **ACTIVE→switch, stream idle:**
  - enable=0 at N+1.
  - sel updates at N+2.
  - enable=1 and done at N+2+SETTLE_CYCLES.
- **Drain wait:** a tlast beat in DRAIN cycle k exits DRAIN at k+1 (in_packet is registered).
- **Forced flush:** drop=1 starts DRAIN_TIMEOUT cycles after DRAIN entry.
- **req_ready:** registered and deasserted the cycle after accept. A second request cannot be accepted until done has been seen.
- **gpio:** all bits change only on clock edges, with no combinational path from inputs.

## Configuration
- **GPIO_MUX_CTRL_TIMEOUT_EN defined:**
  - The DRAIN timeout counter and the FLUSH state are built.
  - drop is asserted on timeout.
- **GPIO_MUX_CTRL_TIMEOUT_EN undefined:**
  - DRAIN waits indefinitely for a boundary.
  - FLUSH is unreachable and not built.
  - gpio[1] and done_timeout are tied to 0.

## Test plan
- **Reset, idle start:** after reset, request sel=1, enable=1 with SETTLE_CYCLES=4 at N. Required: gpio=0 before N; sel=1 at N+1; gpio=3'b101 and done at N+5.
- **Clean switch:** ACTIVE on sel=0 with the stream idle; request sel=1 at N. Required: enable=0 at N+1; sel=1 at N+2; enable=1 and done at N+6; done_timeout=0.
- **Drain on packet:** a 10-beat packet is mid-flight when a switch is requested. Required: sel holds until 1 cycle after the tlast beat; drop is never asserted.
- **Forced flush (macro on, DRAIN_TIMEOUT=16):** packet without tlast. Required: drop=1 for 4 cycles starting 16 cycles after DRAIN entry; done_timeout=1 with done.
- **Same-select and disable:** request current sel → done at N+1 with gpio unchanged. Request req_enable=0 → enable drops, a drain occurs, state returns to IDLE, gpio[0]=0.
- **Reset mid-SWITCH:** assert rst_n=0 during SWITCH. Required: gpio=0 immediately with no clock edge; IDLE after release.

Source files
------------

// File: rtl/gpio_mux_ctrl.sv
// gpio_mux_ctrl: sequencer that safely switches the stream mux GPIO control word {sel, drop, enable}.
// Define GPIO_MUX_CTRL_TIMEOUT_EN to build the DRAIN timeout and the FLUSH (drop) state.
module gpio_mux_ctrl #(
    parameter int unsigned SEL_WIDTH     = 1,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DRAIN_TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SEL_WIDTH-1:0] req_sel,
    input  logic                 req_enable,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    input  logic                 mon_tlast,
    output logic [SEL_WIDTH+1:0] gpio,
    output logic                 busy,
    output logic                 done,
    output logic                 done_timeout
);
    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_FLUSH, S_SWITCH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 in_packet_q, in_packet_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic [SEL_WIDTH-1:0] lat_sel_q, lat_sel_d;
    logic                 lat_en_q, lat_en_d;
    logic                 enable_q, enable_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
    logic                 drop_q, drop_d;
    logic                 to_flag_q, to_flag_d;
    logic                 done_to_q, done_to_d;
`endif
    logic                 accept;
    logic                 beat;

    assign accept = req_valid & req_ready_q;
    assign beat   = mon_tvalid & mon_tready;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        lat_sel_d   = lat_sel_q;
        lat_en_d    = lat_en_q;
        done_d      = 1'b0;
        in_packet_d = in_packet_q;
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
        to_flag_d   = to_flag_q;
`endif
        if (beat) begin
            in_packet_d = ~mon_tlast;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_enable) begin
                        state_d = S_SWITCH;
                        sel_d   = req_sel;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    if (req_enable && (req_sel == sel_q)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_DRAIN;
                        lat_sel_d = req_sel;
                        lat_en_d  = req_enable;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_packet_q) begin
                    if (lat_en_q) begin
                        state_d = S_SWITCH;
                        sel_d   = lat_sel_q;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
                else if (cnt_q == DRAIN_LAST) begin
                    state_d   = S_FLUSH;
                    to_flag_d = 1'b1;
                end
`endif
            end
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
            S_FLUSH: begin
                if (cnt_q == SETTLE_LAST) begin
                    // The dropped packet is gone; restart boundary tracking clean.
                    in_packet_d = 1'b0;
                    if (lat_en_q) begin
                        state_d = S_SWITCH;
                        sel_d   = lat_sel_q;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
`endif
            S_SWITCH: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = S_ACTIVE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
        done_to_d = done_d & to_flag_q;
        if (done_d) begin
            to_flag_d = 1'b0;
        end
        drop_d = (state_d == S_FLUSH);
`endif
        cnt_d       = (state_d != state_q) ? '0 : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
        // Outputs are decoded from the next state so every gpio bit leaves a flop.
        enable_d    = (state_d == S_ACTIVE);
        busy_d      = (state_d == S_DRAIN) || (state_d == S_FLUSH) || (state_d == S_SWITCH);
        req_ready_d = ((state_d == S_IDLE) || (state_d == S_ACTIVE)) && !accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_packet_q <= 1'b0;
            sel_q       <= '0;
            lat_sel_q   <= '0;
            lat_en_q    <= 1'b0;
            enable_q    <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
            drop_q      <= 1'b0;
            to_flag_q   <= 1'b0;
            done_to_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_packet_q <= in_packet_d;
            sel_q       <= sel_d;
            lat_sel_q   <= lat_sel_d;
            lat_en_q    <= lat_en_d;
            enable_q    <= enable_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
            drop_q      <= drop_d;
            to_flag_q   <= to_flag_d;
            done_to_q   <= done_to_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
    assign gpio         = {sel_q, drop_q, enable_q};
    assign done_timeout = done_to_q;
`else
    assign gpio         = {sel_q, 1'b0, enable_q};
    assign done_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_mux_ctrl.sv
// Scoreboard bench for gpio_mux_ctrl: random requests and stream traffic against an event-time model.
// Honours GPIO_MUX_CTRL_TIMEOUT_EN the same way as the design.
module tb_gpio_mux_ctrl;
    localparam int unsigned SW = 2;
    localparam int unsigned S  = 4;
    localparam int unsigned T  = 16;
    localparam int K_SHORT = 0;
    localparam int K_START = 1;
    localparam int K_DRAIN = 2;
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
    localparam bit HAS_TO = 1'b1;
`else
    localparam bit HAS_TO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_enable = 1'b0;
    logic [SW-1:0] req_sel = '0;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          mon_tlast = 1'b0;
    logic          req_ready;
    logic          busy;
    logic          done;
    logic          done_timeout;
    logic [SW+1:0] gpio;

    typedef struct {
        int unsigned   due;
        logic [SW+1:0] gpio;
        logic          to;
    } exp_t;

    exp_t          sb[$];
    int unsigned   cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [SW-1:0] sel_m = '0;
    logic          active_m = 1'b0;
    bit            sv[80];
    bit            sr[80];
    bit            sl[80];

    gpio_mux_ctrl #(.SEL_WIDTH(SW), .SETTLE_CYCLES(S), .DRAIN_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_enable(req_enable),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
        .gpio(gpio), .busy(busy), .done(done), .done_timeout(done_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("done_without_request", done, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc, e.due);
                chk("done_gpio", gpio, e.gpio);
                chk("done_timeout", done_timeout, e.to);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [SW-1:0] sel, input logic en, output int unsigned n);
        bit got;
        got = 1'b0;
        n = 0;
        req_sel = sel;
        req_enable = en;
        req_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1'b1;
                n = cyc;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!got) begin
            chk("req_accept", req_ready, 1'b1);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $fatal(1, "request never accepted");
        end
    endtask

    task automatic run_req(input logic [SW-1:0] sel, input logic en, input int pre, input int post,
                           input bit stuck_req);
        int unsigned n, due, ex, len, j;
        int          kind;
        bit          stuck;
        logic [SW-1:0] old_sel, new_sel, es;
        logic        en_fin, ee, ed, eb, er;
        exp_t        e;
        old_sel = sel_m;
        if (!active_m) kind = en ? K_START : K_SHORT;
        else if (en && sel == sel_m) kind = K_SHORT;
        else kind = K_DRAIN;
        stuck = 1'b0;
        len = 0;
        if (kind != K_DRAIN) pre = 0;
        if (pre > 0) begin
            stuck = stuck_req && HAS_TO;
            if (!stuck) begin
                if (post < 1) post = 1;
                if (HAS_TO && post > 7) post = 7;
                if (post > 30) post = 30;
                for (int b = 1; b <= post; b++) begin
                    if ($urandom_range(0, 1) == 1) begin
                        len++;
                        sv[len] = 1'($urandom_range(0, 1));
                        sr[len] = sv[len] ? 1'b0 : 1'($urandom_range(0, 1));
                        sl[len] = 1'($urandom_range(0, 1));
                    end
                    len++;
                    sv[len] = 1'b1;
                    sr[len] = 1'b1;
                    sl[len] = (b == post);
                end
            end
            for (int i = 0; i < pre; i++) begin
                mon_tvalid = 1'b1;
                mon_tready = 1'b1;
                mon_tlast  = 1'b0;
                @(posedge clk);
                #1;
            end
            mon_tvalid = 1'b0;
        end

        issue(sel, en, n);
        ex = 0;
        if (kind == K_SHORT) due = n + 1;
        else if (kind == K_START) due = n + 1 + S;
        else begin
            if (pre == 0) ex = n + 2;
            else if (stuck) ex = n + 1 + T + S;
            else ex = n + len + 2;
            due = en ? ex + S : ex;
        end
        en_fin  = (kind == K_SHORT) ? active_m : en;
        new_sel = (kind == K_SHORT || !en) ? old_sel : sel;
        e.due  = due;
        e.gpio = {new_sel, 1'b0, en_fin};
        e.to   = stuck;
        sb.push_back(e);
        active_m = en_fin;
        sel_m    = new_sel;

        for (int unsigned c = n + 1; c <= due; c++) begin
            j = c - n;
            if (j <= len) begin
                mon_tvalid = sv[j];
                mon_tready = sr[j];
                mon_tlast  = sl[j];
            end else begin
                mon_tvalid = 1'b0;
                mon_tready = 1'($urandom_range(0, 1));
                mon_tlast  = 1'b0;
            end
            @(negedge clk);
            er = (kind != K_SHORT) && (c == due);
            eb = (kind != K_SHORT) && (c < due);
            ed = stuck && (c >= n + 1 + T) && (c <= n + T + S);
            if (kind == K_SHORT) begin
                es = old_sel;
                ee = en_fin;
            end else if (kind == K_START) begin
                es = sel;
                ee = (c == due);
            end else begin
                es = (c >= ex && en) ? sel : old_sel;
                ee = (c == due) && en;
            end
            chk("trace", {req_ready, busy, gpio}, {er, eb, es, ed, ee});
            if (c < due) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        mon_tvalid = 1'b0;
        chk("done_seen", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int unsigned n;
        logic [SW-1:0] rs;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gpio", gpio, 0);
        chk("reset_ready", req_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_done_timeout", done_timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", req_ready, 1);
        chk("gpio_after_reset", gpio, 0);
        @(posedge clk);
        #1;

        run_req(2'd1, 1'b1, 0, 0, 1'b0);
        run_req(2'd1, 1'b1, 0, 0, 1'b0);
        run_req(2'd2, 1'b1, 0, 0, 1'b0);
        run_req(2'd3, 1'b1, 3, 7, 1'b0);
`ifdef GPIO_MUX_CTRL_TIMEOUT_EN
        run_req(2'd0, 1'b1, 4, 0, 1'b1);
        run_req(2'd2, 1'b0, 2, 0, 1'b1);
        run_req(2'd1, 1'b1, 0, 0, 1'b0);
`else
        run_req(2'd0, 1'b1, 2, 25, 1'b0);
`endif
        run_req(2'd1, 1'b0, 2, 3, 1'b0);
        run_req(2'd3, 1'b0, 0, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            rs = SW'($urandom_range(0, 3));
            run_req(rs, ($urandom_range(0, 3) != 0), $urandom_range(0, 4),
                    $urandom_range(1, 30), ($urandom_range(0, 3) == 0));
        end

        run_req(sel_m, 1'b0, 0, 0, 1'b0);
        issue(2'd1, 1'b1, n);
        @(negedge clk);
        chk("switch_sel", {busy, gpio}, {1'b1, 2'd1, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_async_gpio", gpio, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_ready", req_ready, 0);
        sel_m = '0;
        active_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst_ready", req_ready, 1);
        chk("idle_after_rst_gpio", gpio, 0);
        @(posedge clk);
        #1;
        run_req(2'd2, 1'b1, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
